cla_pipe_addsub: RTL
====================

# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor for the factorial datapath, replacing fixed 4-bit ripple-of-CLA adders on wide operands. Operands are split into 4-bit lookahead groups; groups are spread across pipeline stages so the carry chain is broken by registers. A valid/ready handshake moves operations through the stages, and each result carries carry-out and signed overflow. It sits between the multiplier's partial-product accumulation and the result register.

## Interface
- `WIDTH`, 16: operand/result width. It must be a multiple of 4.
- `STAGE_GRP`, 1: number of 4-bit groups resolved per pipeline stage. `WIDTH/4` must be divisible by `STAGE_GRP`.
- Derived: `NGRP = WIDTH/4`, and latency `L = NGRP/STAGE_GRP` pipeline registers.
- `clk`, in, 1: the single clock; everything is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: the operation on `a`/`b`/`ci`/`sub` is valid.
- `in_ready`, out, 1: the block can accept an operation this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `ci`, in, 1: carry-in. Used only when `sub=0`.
- `sub`, in, 1: when 1, compute `a + ~b + 1`; `ci` is ignored.
- `out_valid`, out, 1: `s`/`co`/`ov` hold a valid result.
- `out_ready`, in, 1: downstream accepts the result this cycle.
- `s`, out, WIDTH: sum or difference.
- `co`, out, 1: carry out of bit WIDTH-1. In subtract mode, 0 means borrow.
- `ov`, out, 1: two's-complement signed overflow.

## Operation
- Operand prep: `bx = sub ? ~b : b` and `c0 = sub ? 1 : ci`.
- Group g computes generate/propagate over bits `[4g+3:4g]` and lookahead carries c1..c3. The group carry-out is `G | P&cin`.
- Stage k (1..L) resolves groups `(k-1)*STAGE_GRP .. k*STAGE_GRP-1`:
  - Stage 1 works combinationally from the inputs.
  - Stage k>1 works from the stage k-1 register.
- Each stage register holds:
  - its valid bit;
  - the sum bits resolved so far (lower bits);
  - the not-yet-used upper `a`/`bx` bits;
  - the carry into the next group;
  - the carry into the MSB, which is needed for `ov`.
- Final register: `s` is the full sum, `co` is the carry out of the MSB, and `ov = c_in(MSB) ^ co`.
- Stall is global:
  - `en = !out_valid || out_ready`, and `in_ready = en`.
  - When `en=0`, every stage holds its contents, including valid bits.
  - When `en=1`, every stage shifts and stage 1 captures `in_valid && in_ready`.
- A cycle with `in_valid=0` and `en=1` inserts a bubble (valid=0). Bubbles are not compressed.
- Results leave in strict acceptance order. There is no reordering, dropping or duplication.
- Reset (async assert, any time): all valid bits, `s`, `co` and `ov` go to 0 immediately. Operations in flight are discarded. Deassertion is synchronous to `clk`, by the integration's reset synchroniser.
- Reset values: `out_valid=0`, `s=0`, `co=0`, `ov=0`, and `in_ready=1` (this follows from `out_valid=0`).

## Timing
- An operation accepted at rising edge n is presented on `s`/`co`/`ov` with `out_valid=1` after edge n+L-1.
- Result latency is L cycles. For `WIDTH=16` and `STAGE_GRP=1`, L=4.
- Throughput is one operation per cycle while `out_ready=1`.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.
- A result transfers on an edge where `out_valid && out_ready`.
- While `out_valid=1` and `out_ready=0`, `s`/`co`/`ov` are stable.
- Critical path per stage: `STAGE_GRP` cascaded group lookaheads plus operand inversion. The inversion applies in stage 1 only.

## Configuration
- Macro `CLA_PIPE_SAT_EN`.
- Defined: on signed overflow, `s` is clamped at the final stage.
  - Positive overflow (`ov=1`, `a[MSB]=bx[MSB]=0`) clamps to `{0,{WIDTH-1{1}}}`.
  - Negative overflow clamps to `{1,{WIDTH-1{0}}}`.
  - `ov` and `co` still report the raw values.
- Undefined: `s` wraps modulo 2^WIDTH and no clamp logic is built.

## Test plan
All scenarios use WIDTH=16 and STAGE_GRP=1 (L=4) unless noted.
- Reset: assert `reset_n=0` mid-cycle -> immediately `out_valid=0`, `s=0`, `co=0`, `ov=0`, `in_ready=1`.
- Overflow: add `a=0x7FFF`, `b=0x0001`, `ci=0` -> 4 cycles later `s=0x8000`, `co=0`, `ov=1`. With `CLA_PIPE_SAT_EN`: `s=0x7FFF`.
- Carry chain: add `a=0xFFFF`, `b=0x0000`, `ci=1` -> `s=0x0000`, `co=1`, `ov=0`. Subtract `a=0x0000`, `b=0x0001` -> `s=0xFFFF`, `co=0`, `ov=0`.
- Streaming: 8 back-to-back random operations with `out_ready=1` -> 8 consecutive `out_valid` cycles in order, each matching the reference `a±b`.
- Backpressure:
  - Fill the pipe and hold `out_ready=0` for 3 cycles -> `in_ready=0`, outputs frozen, no loss.
  - Release -> the remaining results drain in order.
- Reset mid-flight and alternate config:
  - Accept 3 operations, then pulse `reset_n` low -> no `out_valid` afterwards.
  - Repeat the overflow case with WIDTH=32 and STAGE_GRP=2 (L=4): `a=0x7FFFFFFF`, `b=1` -> `s=0x80000000`, `ov=1`.

Source files
------------

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: operation/result handshake bundle for cla_pipe_addsub.
//   master : the client side; drives operands and out_ready, observes results.
//   slave  : the adder side; accepts operands, presents s/co/ov with out_valid.
// Signals: in_valid/in_ready with a, b, ci, sub on the request side;
//          out_valid/out_ready with s, co, ov on the result side.
interface cla_pipe_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ov
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ov
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
//   Operands are split into 4-bit lookahead groups; each pipeline stage
//   resolves STAGE_GRP groups, so latency is L = (WIDTH/4)/STAGE_GRP cycles.
//   A global stall (en = !out_valid || out_ready) freezes every stage.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (clears valids and outputs)
//   bus     : cla_pipe_addsub_if.slave (in_valid/in_ready, a, b, ci, sub,
//             out_valid/out_ready, s, co, ov)
// Build option: define CLA_PIPE_SAT_EN to clamp s on signed overflow at the
//   final stage (co/ov still report raw values); otherwise s wraps.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned STAGE_GRP = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  cla_pipe_addsub_if.slave    bus
);

  localparam int unsigned NGRP = WIDTH / 4;
  localparam int unsigned L    = NGRP / STAGE_GRP;

  // Stage registers: index k holds the state after stage k+1.
  logic [L-1:0]     v_q;
  logic [WIDTH-1:0] sum_q [L];
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] bx_q  [L];
  logic [L-1:0]     c_q;
  logic [L-1:0]     cmsb_q;

  logic [WIDTH-1:0] sum_d [L];
  logic [WIDTH-1:0] a_d   [L];
  logic [WIDTH-1:0] bx_d  [L];
  logic [L-1:0]     c_d;
  logic [L-1:0]     cmsb_d;

  logic en;

  // One 4-bit lookahead group. Returns {carry into bit 3, group carry-out, sum}.
  function automatic logic [5:0] grp(input logic [3:0] ga, input logic [3:0] gb,
                                     input logic cin);
    logic [3:0] g, p, c;
    logic       gg, pp;
    g    = ga & gb;
    p    = ga ^ gb;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    pp   = &p;
    return {c[3], gg | (pp & cin), p ^ c};
  endfunction

  always_comb begin
    logic [WIDTH-1:0] av, bv, sv;
    logic             cv, cm;
    logic [5:0]       r;
    int unsigned      gi;
    av = '0;
    bv = '0;
    sv = '0;
    cv = 1'b0;
    cm = 1'b0;
    r  = '0;
    gi = 0;
    for (int unsigned k = 0; k < L; k++) begin
      if (k == 0) begin
        // Operand inversion lives only in front of the first stage.
        av = bus.a;
        bv = bus.sub ? ~bus.b : bus.b;
        sv = '0;
        cv = bus.sub ? 1'b1 : bus.ci;
      end else begin
        av = a_q[k-1];
        bv = bx_q[k-1];
        sv = sum_q[k-1];
        cv = c_q[k-1];
      end
      cm = 1'b0;
      for (int unsigned j = 0; j < STAGE_GRP; j++) begin
        gi = k * STAGE_GRP + j;
        r  = grp(av[4*gi +: 4], bv[4*gi +: 4], cv);
        sv[4*gi +: 4] = r[3:0];
        cv = r[4];
        cm = r[5];
      end
      // cm is only meaningful in the last stage, whose last group holds the MSB.
      sum_d[k]  = sv;
      a_d[k]    = av;
      bx_d[k]   = bv;
      c_d[k]    = cv;
      cmsb_d[k] = cm;
    end
`ifdef CLA_PIPE_SAT_EN
    // Overflow implies a and bx share a sign; that sign picks the clamp rail.
    if (cmsb_d[L-1] ^ c_d[L-1]) begin
      sum_d[L-1] = a_d[L-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign en = !v_q[L-1] || bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q    <= '0;
      c_q    <= '0;
      cmsb_q <= '0;
      for (int unsigned k = 0; k < L; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
      end
    end else if (en) begin
      v_q[0] <= bus.in_valid;
      for (int unsigned k = 1; k < L; k++) begin
        v_q[k] <= v_q[k-1];
      end
      c_q    <= c_d;
      cmsb_q <= cmsb_d;
      for (int unsigned k = 0; k < L; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        bx_q[k]  <= bx_d[k];
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[L-1];
  assign bus.s         = sum_q[L-1];
  assign bus.co        = c_q[L-1];
  assign bus.ov        = cmsb_q[L-1] ^ c_q[L-1];

endmodule
